// File: rtl/decoder_scan_sequencer_if.sv
// Control/status bundle between a scan controller and the decoder scan sequencer.
// The sequencer takes the slave side; whoever drives start/stop takes the master side.
interface decoder_scan_sequencer_if;
  logic       start;
  logic       stop;
  logic       mode;
  logic [3:0] mask;
  logic [1:0] sel;
  logic       en;
  logic       busy;
  logic       ch_strobe;
  logic       done;

  modport master (
    output start, stop, mode, mask,
    input  sel, en, busy, ch_strobe, done
  );

  modport slave (
    input  start, stop, mode, mask,
    output sel, en, busy, ch_strobe, done
  );
endinterface

// File: rtl/decoder_scan_sequencer.sv
// Drives sel/en of a 2-to-4 decoder so that the unmasked outputs are visited in
// ascending order, each held for DWELL cycles. One-shot or continuous scanning,
// start/stop control, and a done pulse at the end of a one-shot pass.
module decoder_scan_sequencer #(
  parameter int DWELL = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  decoder_scan_sequencer_if.slave  bus
);

  localparam int CNT_W = $clog2(DWELL) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             strobe_q, strobe_d;
  logic             done_q, done_d;
  logic [3:0]       mask_q, mask_d;
  logic             mode_q, mode_d;

  // Index of the lowest set bit; callers guarantee the mask is non-zero.
  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) begin
        r = 2'(i);
      end
    end
    return r;
  endfunction

  // {found, index} of the lowest set bit strictly above cur.
  function automatic logic [2:0] next_above(input logic [3:0] m, input logic [1:0] cur);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if ((i > int'(cur)) && m[i]) begin
        r = {1'b1, 2'(i)};
      end
    end
    return r;
  endfunction

  logic [2:0] nxt_s;
  assign nxt_s = next_above(mask_q, sel_q);

  // Next-state and registered-output computation for the IDLE/SCAN sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    en_d     = en_q;
    busy_d   = busy_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    mask_d   = mask_q;
    mode_d   = mode_q;

    case (state_q)
      ST_IDLE: begin
        sel_d  = 2'd0;
        en_d   = 1'b0;
        busy_d = 1'b0;
        cnt_d  = {CNT_W{1'b0}};
        if (bus.start && !bus.stop) begin
          if (bus.mask != 4'b0000) begin
            mask_d   = bus.mask;
            mode_d   = bus.mode;
            state_d  = ST_SCAN;
            sel_d    = lowest_set(bus.mask);
            en_d     = 1'b1;
            busy_d   = 1'b1;
            strobe_d = 1'b1;
          end else begin
            // Nothing to scan: report completion immediately.
            done_d = 1'b1;
          end
        end else begin
          done_d = 1'b0;
        end
      end

      ST_SCAN: begin
        if (bus.stop) begin
          // Abort wins over any advance in the same cycle; no done pulse.
          state_d = ST_IDLE;
          sel_d   = 2'd0;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
          if (nxt_s[2]) begin
            sel_d    = nxt_s[1:0];
            cnt_d    = {CNT_W{1'b0}};
            strobe_d = 1'b1;
          end else if (mode_q) begin
            sel_d    = lowest_set(mask_q);
            cnt_d    = {CNT_W{1'b0}};
            strobe_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            sel_d   = 2'd0;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = {CNT_W{1'b0}};
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        sel_d   = 2'd0;
        en_d    = 1'b0;
        busy_d  = 1'b0;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      sel_q    <= 2'd0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      mask_q   <= 4'b0000;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      mask_q   <= mask_d;
      mode_q   <= mode_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.en        = en_q;
  assign bus.busy      = busy_q;
  assign bus.ch_strobe = strobe_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Scoreboard bench: two sequencers (DWELL=4 and DWELL=1) receive identical stimulus.
// A queue-based reference model predicts each cycle's outputs; a monitor compares.
module tb_decoder_scan_sequencer;

  logic clk = 1'b0;
  logic reset_r;
  always #5 clk = ~clk;

  decoder_scan_sequencer_if if4 ();
  decoder_scan_sequencer_if if1 ();

  decoder_scan_sequencer #(.DWELL(4)) u_dut4 (.clk(clk), .reset(reset_r), .bus(if4));
  decoder_scan_sequencer #(.DWELL(1)) u_dut1 (.clk(clk), .reset(reset_r), .bus(if1));

  // Downstream 2-to-4 decoder fed by the DWELL=1 sequencer.
  logic [3:0] dout1;
  always_comb begin
    dout1 = 4'b0000;
    if (if1.en) dout1[if1.sel] = 1'b1;
  end

  // Reference model state, index 0 -> DWELL=4, index 1 -> DWELL=1.
  int         plan  [2][$];   // per-cycle entries: sel | (strobe << 2)
  logic [5:0] exp_q [2][$];   // {done, strobe, busy, en, sel}
  logic       m_busy[2];
  logic       m_mode[2];
  logic [3:0] m_mask[2];
  int         n_vec = 0;
  int         n_err = 0;

  function automatic int dwell_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  // One pass over the captured mask: each set channel, ascending, for its dwell.
  function automatic void fill_pass(input int k);
    for (int ch = 0; ch < 4; ch++)
      if (m_mask[k][ch])
        for (int c = 0; c < dwell_of(k); c++)
          plan[k].push_back(ch + ((c == 0) ? 4 : 0));
  endfunction

  function automatic logic [5:0] model_step(input int k, input logic rst, input logic st,
                                             input logic sp, input logic md, input logic [3:0] mk);
    logic [5:0] o;
    int e;
    o = 6'd0;
    if (rst) begin
      m_busy[k] = 1'b0; m_mode[k] = 1'b0; m_mask[k] = 4'b0000;
      plan[k].delete();
    end else if (!m_busy[k]) begin
      if (st && !sp) begin
        if (mk == 4'b0000) begin
          o[5] = 1'b1;
        end else begin
          m_mask[k] = mk; m_mode[k] = md; m_busy[k] = 1'b1;
          fill_pass(k);
          e = plan[k].pop_front();
          o = {1'b0, e[2], 1'b1, 1'b1, e[1:0]};
        end
      end
    end else if (sp) begin
      m_busy[k] = 1'b0;
      plan[k].delete();
    end else begin
      if (plan[k].size() == 0 && m_mode[k]) fill_pass(k);
      if (plan[k].size() == 0) begin
        m_busy[k] = 1'b0;
        o[5] = 1'b1;
      end else begin
        e = plan[k].pop_front();
        o = {1'b0, e[2], 1'b1, 1'b1, e[1:0]};
      end
    end
    return o;
  endfunction

  // Apply one cycle of stimulus to both DUTs and queue the predicted response.
  task automatic drive(input logic rst, input logic st, input logic sp,
                       input logic md, input logic [3:0] mk);
    @(negedge clk);
    reset_r = rst;
    if4.start = st; if4.stop = sp; if4.mode = md; if4.mask = mk;
    if1.start = st; if1.stop = sp; if1.mode = md; if1.mask = mk;
    for (int k = 0; k < 2; k++) exp_q[k].push_back(model_step(k, rst, st, sp, md, mk));
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 4'($urandom_range(0, 15)));
  endtask

  // Monitor: after every edge, pop the prediction and compare against the DUT outputs.
  always @(posedge clk) begin
    logic [5:0] act;
    logic [5:0] exp;
    logic [3:0] exp_dout;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (exp_q[k].size() != 0) begin
        exp = exp_q[k].pop_front();
        act = (k == 0) ? {if4.done, if4.ch_strobe, if4.busy, if4.en, if4.sel}
                       : {if1.done, if1.ch_strobe, if1.busy, if1.en, if1.sel};
        n_vec++;
        if (act !== exp) begin
          n_err++;
          $display("FAIL outputs dwell=%0d t=%0t: got done/strobe/busy/en/sel=%b required %b",
                   dwell_of(k), $time, act, exp);
        end
        if (k == 1) begin
          exp_dout = 4'b0000;
          if (exp[2]) exp_dout = 4'b0001 << exp[1:0];
          n_vec++;
          if (dout1 !== exp_dout) begin
            n_err++;
            $display("FAIL decoder_dout t=%0t: got %b required %b", $time, dout1, exp_dout);
          end
        end
      end
    end
  end

  initial begin
    reset_r = 1'b1;
    if4.start = 1'b0; if4.stop = 1'b0; if4.mode = 1'b0; if4.mask = 4'b0000;
    if1.start = 1'b0; if1.stop = 1'b0; if1.mode = 1'b0; if1.mask = 4'b0000;

    // Reset values.
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);

    // One-shot full mask (also the DWELL=1 consecutive-channel case).
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'b1111);
    idle(20);

    // One-shot sparse mask.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'b1010);
    idle(12);

    // Continuous 0101, stop in cycle 2 of the second sel=2 dwell.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'b0101);
    idle(13);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b1111);
    idle(3);

    // Empty mask, then start+stop together in IDLE.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
    idle(2);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'b1111);
    idle(3);

    // Reset while sel=2 mid-scan.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'b1111);
    idle(9);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    idle(2);

    // Start during SCAN is ignored.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'b1111);
    idle(2);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'b0001);
    idle(18);

    // Single-bit continuous mask.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'b0100);
    idle(14);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)));
    end
    idle(2);

    #3;
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (exp_q[k].size() != 0) begin
        n_err++;
        $display("FAIL drain dwell=%0d: got %0d pending required 0", dwell_of(k), exp_q[k].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
